// File: rtl/row_packer_if.sv
// Cell-in / row-out handshake bundle for row_packer.
// Optional row_parity exists only when ROW_PACKER_PARITY_EN is defined.
interface row_packer_if #(
    parameter int CELLS  = 7,
    parameter int CELL_W = 3,
    parameter int ROWS   = 14
);
    localparam int ROW_W = CELLS * CELL_W;
    localparam int NUM_W = ($clog2(ROWS) < 1) ? 1 : $clog2(ROWS);

    logic [CELL_W-1:0] cell_in;
    logic              cell_valid;
    logic              cell_ready;
    logic              row_abort;
    logic [ROW_W-1:0]  row_out;
    logic              row_valid;
    logic              row_ready;
    logic [NUM_W-1:0]  row_num;
`ifdef ROW_PACKER_PARITY_EN
    logic              row_parity;
`endif

    modport master (
        output cell_in, cell_valid, row_abort, row_ready,
        input  cell_ready, row_out, row_valid, row_num
`ifdef ROW_PACKER_PARITY_EN
        , input row_parity
`endif
    );

    modport slave (
        input  cell_in, cell_valid, row_abort, row_ready,
        output cell_ready, row_out, row_valid, row_num
`ifdef ROW_PACKER_PARITY_EN
        , output row_parity
`endif
    );
endinterface

// File: rtl/row_packer.sv
// Packs CELLS cells of CELL_W bits into a row; row_valid rises 1 cycle after the last cell is accepted.
// The last cell of a row is held off while the previous row is unconsumed; optional ROW_PACKER_PARITY_EN adds row_parity.
module row_packer #(
    parameter int CELLS  = 7,
    parameter int CELL_W = 3,
    parameter int ROWS   = 14
) (
    input  logic       clk,
    input  logic       rst,
    row_packer_if.slave bus
);
    localparam int ROW_W = CELLS * CELL_W;
    localparam int COL_W = $clog2(CELLS);
    localparam int NUM_W = ($clog2(ROWS) < 1) ? 1 : $clog2(ROWS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(CELLS - 1);
    localparam logic [NUM_W-1:0] LAST_NUM = NUM_W'(ROWS - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] asm_q, asm_d;
    logic [ROW_W-1:0] out_q, out_d;
    logic             vld_q, vld_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic             ready;
    logic             accept;
    logic             last;
    logic             hshk;
    logic [ROW_W-1:0] row_full;

    // Only the closing cell waits on the output register; earlier slots fill freely.
    always_comb begin
        ready  = !bus.row_abort && !((col_q == LAST_COL) && vld_q && !bus.row_ready);
        accept = bus.cell_valid && ready;
        last   = accept && (col_q == LAST_COL);
        hshk   = vld_q && bus.row_ready;

        row_full = asm_q;
        for (int k = 0; k < CELLS; k++) begin
            if (col_q == COL_W'(k)) begin
                row_full[k*CELL_W +: CELL_W] = bus.cell_in;
            end
        end

        col_d = col_q;
        asm_d = asm_q;
        if (bus.row_abort) begin
            col_d = '0;
            asm_d = '0;
        end else if (accept) begin
            if (last) begin
                col_d = '0;
                asm_d = '0;
            end else begin
                col_d = col_q + COL_W'(1);
                asm_d = row_full;
            end
        end

        out_d = out_q;
        vld_d = vld_q;
        num_d = num_q;
        if (hshk) begin
            vld_d = 1'b0;
            num_d = (num_q == LAST_NUM) ? '0 : num_q + NUM_W'(1);
        end
        if (last) begin
            out_d = row_full;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            asm_q <= '0;
            out_q <= '0;
            vld_q <= 1'b0;
            num_q <= '0;
        end else begin
            col_q <= col_d;
            asm_q <= asm_d;
            out_q <= out_d;
            vld_q <= vld_d;
            num_q <= num_d;
        end
    end

`ifdef ROW_PACKER_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (last) begin
            par_q <= ^row_full;
        end
    end

    assign bus.row_parity = par_q;
`endif

    assign bus.cell_ready = ready;
    assign bus.row_out    = out_q;
    assign bus.row_valid  = vld_q;
    assign bus.row_num    = num_q;
endmodule

// File: tb/tb_row_packer.sv
// Scoreboard bench for row_packer: stimulus pushes expected rows, a negedge monitor checks every presented row.
module tb_row_packer;
    localparam int CELLS  = 7;
    localparam int CELL_W = 3;
    localparam int ROWS   = 14;
    localparam int RW     = CELLS * CELL_W;
    localparam int NW     = $clog2(ROWS);

    typedef struct {
        logic [RW-1:0] row;
        logic [NW-1:0] num;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    logic [RW-1:0] m_row;
    int            m_col;
    int            m_num;

    row_packer_if #(.CELLS(CELLS), .CELL_W(CELL_W), .ROWS(ROWS)) bus();

    row_packer #(.CELLS(CELLS), .CELL_W(CELL_W), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_row = '0;
        m_col = 0;
    endtask

    task automatic model_accept(input logic [CELL_W-1:0] v);
        exp_t e;
        m_row[m_col*CELL_W +: CELL_W] = v;
        m_col++;
        if (m_col == CELLS) begin
            e.row = m_row;
            e.num = NW'(m_num);
            sb.push_back(e);
            m_num = (m_num + 1) % ROWS;
            model_clear();
        end
    endtask

    // Entered and left at posedge+1; holds cell_valid until the DUT takes the cell.
    task automatic send(input logic [CELL_W-1:0] v);
        bit acc = 0;
        bus.cell_in    = v;
        bus.cell_valid = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = bus.cell_ready;
            @(posedge clk);
            #1;
        end
        bus.cell_valid = 1'b0;
        bus.cell_in    = CELL_W'($urandom);
        chk("send_accept", 64'(acc), 64'd1);
        if (acc) model_accept(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        model_clear();
        m_num = 0;
        rst = 1'b0;
    endtask

    // Monitor: any presented row must match the scoreboard head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.row_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_row", 64'(bus.row_out), 64'd0);
                    if (bus.row_out == '0) begin
                        n_fail++;
                        $display("FAIL unexpected_row: got row_valid=1 expected no row");
                    end
                end else begin
                    chk("mon_row_out", 64'(bus.row_out), 64'(sb[0].row));
                    chk("mon_row_num", 64'(bus.row_num), 64'(sb[0].num));
`ifdef ROW_PACKER_PARITY_EN
                    chk("mon_parity", 64'(bus.row_parity), 64'(^sb[0].row));
`endif
                    if (bus.row_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.cell_in    = '0;
        bus.cell_valid = 1'b0;
        bus.row_abort  = 1'b0;
        bus.row_ready  = 1'b0;
        model_clear();
        m_num = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_row_valid", 64'(bus.row_valid), 64'd0);
        chk("rst_row_out", 64'(bus.row_out), 64'd0);
        chk("rst_row_num", 64'(bus.row_num), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_cell_ready", 64'(bus.cell_ready), 64'd1);

        // Basic row 1..7 with consumer ready
        bus.row_ready = 1'b1;
        for (int v = 1; v <= 6; v++) send(CELL_W'(v));
        chk("pre_last_valid", 64'(bus.row_valid), 64'd0);
        send(3'd7);
        chk("basic_valid", 64'(bus.row_valid), 64'd1);
        chk("basic_row", 64'(bus.row_out), 64'h1F58D1);
        chk("basic_num", 64'(bus.row_num), 64'd0);
`ifdef ROW_PACKER_PARITY_EN
        chk("basic_parity", 64'(bus.row_parity), 64'd0);
`endif
        @(posedge clk);
        #1;
        chk("basic_cleared", 64'(bus.row_valid), 64'd0);

        // Backpressure: row 1 held, last cell of row 2 stalled until row_ready
        do_reset();
        bus.row_ready = 1'b0;
        for (int v = 0; v <= 6; v++) send(CELL_W'(v));
        for (int v = 7; v >= 2; v--) send(CELL_W'(v));
        bus.cell_in    = 3'd1;
        bus.cell_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("stall_cell_ready", 64'(bus.cell_ready), 64'd0);
            chk("hold_row", 64'(bus.row_out), 64'h1AC688);
            chk("hold_num", 64'(bus.row_num), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.row_ready = 1'b1;
        send(3'd1);
        chk("swap_valid", 64'(bus.row_valid), 64'd1);
        chk("swap_row", 64'(bus.row_out), 64'h053977);
        chk("swap_num", 64'(bus.row_num), 64'd1);
        @(posedge clk);
        #1;

        // Abort mid-row, then a row of all 7s
        for (int v = 1; v <= 4; v++) send(CELL_W'(v));
        bus.row_abort  = 1'b1;
        bus.cell_valid = 1'b1;
        bus.cell_in    = 3'd5;
        @(negedge clk);
        chk("abort_cell_ready", 64'(bus.cell_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.row_abort  = 1'b0;
        bus.cell_valid = 1'b0;
        model_clear();
        for (int i = 0; i < 7; i++) send(3'd7);
        chk("abort_row", 64'(bus.row_out), 64'h1FFFFF);
`ifdef ROW_PACKER_PARITY_EN
        chk("abort_parity", 64'(bus.row_parity), 64'd1);
`endif
        @(posedge clk);
        #1;

        // 15 back-to-back rows: row_num 0..13 then wraps to 0
        do_reset();
        bus.row_ready = 1'b1;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < CELLS; c++) send(CELL_W'((r + c) % 8));
            chk("wrap_num", 64'(bus.row_num), 64'(r % ROWS));
        end
        @(posedge clk);
        #1;

        // Reset with a held row and a partial row in flight
        bus.row_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(3'd3);
        for (int i = 0; i < 5; i++) send(3'd5);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(bus.row_valid), 64'd0);
        chk("midrst_row", 64'(bus.row_out), 64'd0);
        chk("midrst_num", 64'(bus.row_num), 64'd0);
        sb.delete();
        model_clear();
        m_num = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.row_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(3'd2);
        chk("fresh_not_early", 64'(bus.row_valid), 64'd0);
        send(3'd2);
        chk("fresh_row", 64'(bus.row_out), 64'h092492);
        chk("fresh_num", 64'(bus.row_num), 64'd0);

        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/row_packer.md
ROW_PACKER -- requirements
Module: row_packer

Interface
REQ-001 The block SHALL have parameter CELLS, default 7, meaning number of cells packed per row (legal 2..32).
REQ-002 The block SHALL have parameter CELL_W, default 3, meaning bits per cell (legal 1..8).
REQ-003 The block SHALL have parameter ROWS, default 14, meaning rows per frame; row_num counts 0..ROWS-1 (legal 2..256).
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port cell_in, input, CELL_W, cell value offered.
REQ-007 Port cell_valid, input, 1, cell_in is offered this cycle.
REQ-008 Port cell_ready, output, 1, block accepts cell_in this cycle.
REQ-009 Port row_abort, input, 1, synchronous discard of the partial row.
REQ-010 Port row_out, output, CELLS*CELL_W, packed row.
REQ-011 Port row_valid, output, 1, row_out holds a complete row.
REQ-012 Port row_ready, input, 1, consumer takes row_out this cycle.
REQ-013 Port row_num, output, clog2(ROWS) (min 1), index of the row currently on row_out.

Function
REQ-014 A cell SHALL be accepted when cell_valid and cell_ready are both 1 at a clock edge.
REQ-015 Accepted cells SHALL fill slots in order 0..CELLS-1; slot k SHALL occupy row_out bits [k*CELL_W+CELL_W-1 : k*CELL_W], slot 0 at the LSBs.
REQ-016 A column counter SHALL track the next slot, incrementing per accepted cell and wrapping CELLS-1 -> 0.
REQ-017 Acceptance of the last slot (CELLS-1) SHALL load the complete row into the output holding register, with row_valid=1 on the next cycle (latency 1 from last accept).
REQ-018 row_out and row_num SHALL be stable while row_valid=1 and row_ready=0.
REQ-019 An output handshake (row_valid and row_ready) SHALL clear row_valid next cycle unless a new row is loaded the same edge, then row_valid stays 1 with the new row.
REQ-020 cell_ready SHALL be 0 when row_abort=1, or when the counter is CELLS-1 and row_valid=1 and row_ready=0; otherwise 1 (cells for slots 0..CELLS-2 accepted regardless of output state).
REQ-021 row_abort SHALL reset the column counter to 0 and discard partial slots next edge; it SHALL NOT affect row_out, row_valid or row_num.
REQ-022 row_num SHALL increment by 1 per output handshake, wrapping ROWS-1 -> 0.
REQ-023 Assembly storage SHALL be separate from the output register so the next row can fill while the current one waits.
REQ-024 cell_in SHALL be ignored when not accepted.

Reset
REQ-025 While rst=1: row_out=0, row_valid=0, row_num=0, column counter=0, assembly storage=0; cell_ready SHALL read 1 once rst deasserts.
REQ-026 rst mid-row SHALL discard partial and held rows; no row SHALL be emitted for cells accepted before reset.

Configuration
REQ-027 With macro ROW_PACKER_PARITY_EN defined, the block SHALL add output row_parity (1 bit) = XOR of all bits of row_out, registered with row_out, reset 0, stable under REQ-018.
REQ-028 Without ROW_PACKER_PARITY_EN, row_parity SHALL not exist and behaviour SHALL be otherwise identical.

Verification (CELLS=7, CELL_W=3, ROWS=14)
REQ-029 Reset, cells 1,2,3,4,5,6,7 on consecutive cycles, row_ready=1 -> row_valid one cycle after the 7th accept, row_out=0x1F58D1, row_num=0, row_parity=0 if enabled.
REQ-030 row_ready=0, feed 14 cells -> first row held stable; cell_ready=0 at 7th cell of row 2 until row_ready=1, then row 2 loads the same edge and row_num becomes 1.
REQ-031 Feed 4 cells, assert row_abort with cell_valid=1 -> cell_ready=0 that cycle; next 7 cells 7,7,7,7,7,7,7 -> row_out=0x1FFFFF, row_parity=1.
REQ-032 Emit 15 rows with row_ready=1 -> row_num sequence 0..13 then 0.
REQ-033 Assert rst after 5 cells with a row held -> row_valid=0, row_out=0, row_num=0 immediately; next 7 cells form a fresh row.
